// File: rtl/wb_pipe_stage.sv
// Write-back pipeline stage: registers the incoming instruction, aligns and extends
// load data, drives the register-file write port and counts retired instructions.
module wb_pipe_stage #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [31:0]        in_pc,
  input  logic [31:0]        in_inst,
  input  logic               in_reg_write,
  input  logic [RADDR_W-1:0] in_waddr,
  input  logic               in_mem_to_reg,
  input  logic [DATA_W-1:0]  in_alu_data,
  input  logic [DATA_W-1:0]  in_mem_data,
  input  logic [2:0]         in_load_type,
  input  logic [1:0]         in_byte_off,
  output logic               rf_we,
  output logic [RADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]  rf_wdata,
  output logic [31:0]        debug_pc,
  output logic [31:0]        debug_inst,
  output logic [CNT_W-1:0]   retire_cnt
);

  typedef struct packed {
    logic               valid;
    logic [31:0]        pc;
    logic [31:0]        inst;
    logic               reg_write;
    logic [RADDR_W-1:0] waddr;
    logic               mem_to_reg;
    logic [DATA_W-1:0]  alu_data;
    logic [DATA_W-1:0]  mem_data;
    logic [2:0]         load_type;
    logic [1:0]         byte_off;
  } stage_t;

  stage_t             stage_q, stage_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Select and extend the addressed byte/half; unknown load types act as word loads.
  function automatic logic [DATA_W-1:0] load_align(input stage_t s);
    logic [7:0]        b;
    logic [15:0]       h;
    logic [DATA_W-1:0] r;
    b = s.mem_data[{s.byte_off, 3'b000} +: 8];
    h = s.mem_data[{s.byte_off[1], 4'b0000} +: 16];
    case (s.load_type)
      3'b001:  r = {{(DATA_W-8){b[7]}}, b};
      3'b010:  r = {{(DATA_W-8){1'b0}}, b};
      3'b011:  r = {{(DATA_W-16){h[15]}}, h};
      3'b100:  r = {{(DATA_W-16){1'b0}}, h};
      default: r = s.mem_data;
    endcase
    return r;
  endfunction

  // Next-state: flush clears the whole entry so debug outputs read zero.
  always_comb begin
    stage_d = stage_q;
    cnt_d   = cnt_q;
    if (flush) begin
      stage_d = '0;
    end else if (stall) begin
      stage_d = stage_q;
    end else begin
      stage_d.valid      = in_valid;
      stage_d.pc         = in_pc;
      stage_d.inst       = in_inst;
      stage_d.reg_write  = in_reg_write;
      stage_d.waddr      = in_waddr;
      stage_d.mem_to_reg = in_mem_to_reg;
      stage_d.alu_data   = in_alu_data;
      stage_d.mem_data   = in_mem_data;
      stage_d.load_type  = in_load_type;
      stage_d.byte_off   = in_byte_off;
      if (in_valid) begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_d = cnt_q;
      end
    end
  end

  // Stage register and retire counter with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
      cnt_q   <= '0;
    end else begin
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rf_we      = stage_q.valid & stage_q.reg_write & (stage_q.waddr != '0);
  assign rf_waddr   = stage_q.waddr;
  assign rf_wdata   = stage_q.mem_to_reg ? load_align(stage_q) : stage_q.alu_data;
  assign debug_pc   = stage_q.pc;
  assign debug_inst = stage_q.inst;
  assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_wb_pipe_stage.sv
// Directed self-checking bench for wb_pipe_stage; a second instance with a 4-bit
// retire counter shares the stimulus and is checked for counter wrap.
module tb_wb_pipe_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, in_valid, in_reg_write, in_mem_to_reg;
  logic [31:0] in_pc, in_inst, in_alu_data, in_mem_data;
  logic [4:0]  in_waddr;
  logic [2:0]  in_load_type;
  logic [1:0]  in_byte_off;

  logic        rf_we, rf_we2;
  logic [4:0]  rf_waddr, rf_waddr2;
  logic [31:0] rf_wdata, rf_wdata2, debug_pc, debug_pc2, debug_inst, debug_inst2;
  logic [31:0] retire_cnt;
  logic [3:0]  retire_cnt2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_pipe_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_pc(in_pc), .in_inst(in_inst), .in_reg_write(in_reg_write), .in_waddr(in_waddr),
    .in_mem_to_reg(in_mem_to_reg), .in_alu_data(in_alu_data), .in_mem_data(in_mem_data),
    .in_load_type(in_load_type), .in_byte_off(in_byte_off),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .debug_pc(debug_pc),
    .debug_inst(debug_inst), .retire_cnt(retire_cnt)
  );

  wb_pipe_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_pc(in_pc), .in_inst(in_inst), .in_reg_write(in_reg_write), .in_waddr(in_waddr),
    .in_mem_to_reg(in_mem_to_reg), .in_alu_data(in_alu_data), .in_mem_data(in_mem_data),
    .in_load_type(in_load_type), .in_byte_off(in_byte_off),
    .rf_we(rf_we2), .rf_waddr(rf_waddr2), .rf_wdata(rf_wdata2), .debug_pc(debug_pc2),
    .debug_inst(debug_inst2), .retire_cnt(retire_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic v, input logic [4:0] wa, input logic m2r,
                      input logic [2:0] lt, input logic [1:0] off);
    in_valid      = v;
    in_reg_write  = 1'b1;
    in_waddr      = wa;
    in_mem_to_reg = m2r;
    in_load_type  = lt;
    in_byte_off   = off;
    step();
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0; in_reg_write = 1'b0;
    in_mem_to_reg = 1'b0; in_pc = 32'h0000_0100; in_inst = 32'hDEAD_BEEF;
    in_alu_data = 32'h1234_5678; in_mem_data = 32'h80FF_7F01; in_waddr = 5'd8;
    in_load_type = 3'b000; in_byte_off = 2'b00;
    step(); step();
    chk("rst_we", {31'd0, rf_we}, 32'd0);
    chk("rst_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    chk("rst_pc", debug_pc, 32'd0);
    chk("rst_inst", debug_inst, 32'd0);
    chk("rst_cnt", retire_cnt, 32'd0);
    rst = 1'b0;

    load(1'b1, 5'd8, 1'b0, 3'b000, 2'b00);
    chk("alu_we", {31'd0, rf_we}, 32'd1);
    chk("alu_waddr", {27'd0, rf_waddr}, 32'd8);
    chk("alu_wdata", rf_wdata, 32'h1234_5678);
    chk("alu_pc", debug_pc, 32'h0000_0100);
    chk("alu_inst", debug_inst, 32'hDEAD_BEEF);
    chk("alu_cnt", retire_cnt, 32'd1);

    load(1'b1, 5'd9, 1'b1, 3'b001, 2'd3); chk("lb_off3", rf_wdata, 32'hFFFF_FF80);
    chk("lb_cnt", retire_cnt, 32'd2);
    load(1'b1, 5'd9, 1'b1, 3'b010, 2'd3); chk("lbu_off3", rf_wdata, 32'h0000_0080);
    load(1'b1, 5'd9, 1'b1, 3'b011, 2'd1); chk("lh_off1", rf_wdata, 32'h0000_7F01);
    load(1'b1, 5'd9, 1'b1, 3'b011, 2'd2); chk("lh_off2", rf_wdata, 32'hFFFF_80FF);
    load(1'b1, 5'd9, 1'b1, 3'b100, 2'd3); chk("lhu_off3", rf_wdata, 32'h0000_80FF);
    load(1'b1, 5'd9, 1'b1, 3'b000, 2'd2); chk("lw_off2", rf_wdata, 32'h80FF_7F01);
    load(1'b1, 5'd9, 1'b1, 3'b111, 2'd1); chk("ltype7", rf_wdata, 32'h80FF_7F01);
    load(1'b1, 5'd9, 1'b1, 3'b001, 2'd0); chk("lb_off0", rf_wdata, 32'h0000_0001);
    load(1'b1, 5'd9, 1'b1, 3'b001, 2'd2); chk("lb_off2", rf_wdata, 32'hFFFF_FFFF);
    chk("load_cnt", retire_cnt, 32'd10);

    load(1'b1, 5'd0, 1'b0, 3'b000, 2'd0);
    chk("zero_we", {31'd0, rf_we}, 32'd0);
    chk("zero_cnt", retire_cnt, 32'd11);
    load(1'b0, 5'd5, 1'b0, 3'b000, 2'd0);
    chk("inv_we", {31'd0, rf_we}, 32'd0);
    chk("inv_cnt", retire_cnt, 32'd11);

    in_pc = 32'hBFC0_0010; in_inst = 32'h0000_0013; in_alu_data = 32'hCAFE_F00D;
    load(1'b1, 5'd3, 1'b0, 3'b000, 2'd0);
    chk("st_load_pc", debug_pc, 32'hBFC0_0010);
    chk("st_load_cnt", retire_cnt, 32'd12);
    stall = 1'b1; in_pc = 32'h1234_5678; in_alu_data = 32'd0; in_waddr = 5'd7;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("st_pc", debug_pc, 32'hBFC0_0010);
      chk("st_inst", debug_inst, 32'h0000_0013);
      chk("st_we", {31'd0, rf_we}, 32'd1);
      chk("st_waddr", {27'd0, rf_waddr}, 32'd3);
      chk("st_wdata", rf_wdata, 32'hCAFE_F00D);
      chk("st_cnt", retire_cnt, 32'd12);
    end
    flush = 1'b1;
    step();
    chk("fl_we", {31'd0, rf_we}, 32'd0);
    chk("fl_pc", debug_pc, 32'd0);
    chk("fl_inst", debug_inst, 32'd0);
    chk("fl_cnt", retire_cnt, 32'd12);
    stall = 1'b0;
    step();
    chk("fl_only_we", {31'd0, rf_we}, 32'd0);
    chk("fl_only_cnt", retire_cnt, 32'd12);
    flush = 1'b0;

    // Reset wins over a simultaneous stall, then the first load has normal latency
    stall = 1'b1; rst = 1'b1;
    step();
    chk("rst_st_we", {31'd0, rf_we}, 32'd0);
    chk("rst_st_pc", debug_pc, 32'd0);
    chk("rst_st_cnt", retire_cnt, 32'd0);
    chk("rst_st_cnt4", {28'd0, retire_cnt2}, 32'd0);
    stall = 1'b0; rst = 1'b0; in_pc = 32'h0000_2000; in_alu_data = 32'h0000_00AA;
    load(1'b1, 5'd4, 1'b0, 3'b000, 2'd0);
    chk("post_rst_we", {31'd0, rf_we}, 32'd1);
    chk("post_rst_wdata", rf_wdata, 32'h0000_00AA);
    chk("post_rst_pc", debug_pc, 32'h0000_2000);
    chk("post_rst_cnt4", {28'd0, retire_cnt2}, 32'd1);

    for (int i = 2; i <= 16; i++) begin
      load(1'b1, 5'd4, 1'b0, 3'b000, 2'd0);
      if (i == 15) chk("wrap_cnt15", {28'd0, retire_cnt2}, 32'd15);
    end
    chk("wrap_cnt16", {28'd0, retire_cnt2}, 32'd0);
    chk("wide_cnt16", retire_cnt, 32'd16);
    load(1'b1, 5'd4, 1'b0, 3'b000, 2'd0);
    chk("wrap_cnt17", {28'd0, retire_cnt2}, 32'd1);

    rst = 1'b1; stall = 1'b1;
    step();
    chk("mid_rst_we", {31'd0, rf_we2}, 32'd0);
    chk("mid_rst_waddr", {27'd0, rf_waddr2}, 32'd0);
    chk("mid_rst_wdata", rf_wdata2, 32'd0);
    chk("mid_rst_pc", debug_pc2, 32'd0);
    chk("mid_rst_inst", debug_inst2, 32'd0);
    chk("mid_rst_cnt", {28'd0, retire_cnt2}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
